// File: rtl/vproc_vregfile_banked.sv
// Banked vector register file: NBANKS single-ported banks (bank = addr % NBANKS),
// round-robin read arbitration per bank, and an in-order write buffer that
// drains into idle bank cycles and forwards byte-merged pending data to reads.
// Ports:
//   clk_i, async_rst_ni           clock, asynchronous active-low reset
//   rd_valid_i/rd_addr_i          per-port read request
//   rd_ready_o                    per-port grant (combinational)
//   rd_rvalid_o/rd_data_o         read response, one cycle after grant
//   wr_valid_i/wr_addr_i/wr_data_i/wr_be_i, wr_ready_o   write into buffer
//   wbuf_empty_o                  write buffer holds no entries
module vproc_vregfile_banked #(
   parameter int unsigned VREG_W      = 128,
   parameter int unsigned NREGS       = 32,
   parameter int unsigned NBANKS      = 4,
   parameter int unsigned PORT_RD_CNT = 2,
   parameter int unsigned WBUF_DEPTH  = 2,
   parameter int unsigned ADDR_W      = $clog2(NREGS)
) (
   input  logic                                clk_i,
   input  logic                                async_rst_ni,
   input  logic [PORT_RD_CNT-1:0]              rd_valid_i,
   input  logic [PORT_RD_CNT-1:0][ADDR_W-1:0]  rd_addr_i,
   output logic [PORT_RD_CNT-1:0]              rd_ready_o,
   output logic [PORT_RD_CNT-1:0]              rd_rvalid_o,
   output logic [PORT_RD_CNT-1:0][VREG_W-1:0]  rd_data_o,
   input  logic                                wr_valid_i,
   output logic                                wr_ready_o,
   input  logic [ADDR_W-1:0]                   wr_addr_i,
   input  logic [VREG_W-1:0]                   wr_data_i,
   input  logic [VREG_W/8-1:0]                 wr_be_i,
   output logic                                wbuf_empty_o
);

   localparam int unsigned NB     = VREG_W / 8;
   localparam int unsigned ROWS   = NREGS / NBANKS;
   localparam int unsigned BANK_W = NBANKS > 1 ? $clog2(NBANKS) : 1;
   localparam int unsigned ROW_W  = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int unsigned PW     = PORT_RD_CNT > 1 ? $clog2(PORT_RD_CNT) : 1;
   localparam int unsigned WI_W   = WBUF_DEPTH > 1 ? $clog2(WBUF_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(WBUF_DEPTH + 1);

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      logic [31:0] ax;
      ax = 32'(a);
      return BANK_W'(ax % NBANKS);
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      logic [31:0] ax;
      ax = 32'(a);
      return ROW_W'(ax / NBANKS);
   endfunction

   function automatic logic [WI_W-1:0] wb_inc(input logic [WI_W-1:0] i);
      return (i == WI_W'(WBUF_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   logic [VREG_W-1:0] mem_q [NBANKS][ROWS];

   logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
   logic [VREG_W-1:0] wb_data_q [WBUF_DEPTH];
   logic [NB-1:0]     wb_be_q   [WBUF_DEPTH];
   logic [WI_W-1:0]   head_q;
   logic [WI_W-1:0]   tail_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [PW-1:0]     rr_q     [NBANKS];
   logic [PW-1:0]     bank_win [NBANKS];
   logic [NBANKS-1:0] bank_busy;

   logic [PORT_RD_CNT-1:0]             gnt;
   logic [PORT_RD_CNT-1:0]             rvalid_q;
   logic [PORT_RD_CNT-1:0][VREG_W-1:0] rd_data_q;
   logic [VREG_W-1:0]                  rdata [PORT_RD_CNT];

   logic              full;
   logic              accept;
   logic              drain;
   logic [BANK_W-1:0] head_bank;
   logic [ROW_W-1:0]  head_row;

   assign full      = (cnt_q == CNT_W'(WBUF_DEPTH));
   assign accept    = wr_valid_i && !full;
   assign head_bank = bank_of(wb_addr_q[head_q]);
   assign head_row  = row_of(wb_addr_q[head_q]);
   // A full buffer drains regardless of reads; otherwise only into an idle bank.
   assign drain     = (cnt_q != '0) && (full || !bank_busy[head_bank]);

   assign wr_ready_o   = !full;
   assign wbuf_empty_o = (cnt_q == '0);
   assign rd_ready_o   = gnt;
   assign rd_rvalid_o  = rvalid_q;
   assign rd_data_o    = rd_data_q;

   always_comb begin
      logic [PW-1:0] pi;
      pi        = '0;
      bank_busy = '0;
      gnt       = '0;
      for (int b = 0; b < NBANKS; b++) begin
         bank_win[b] = '0;
         for (int k = 0; k < PORT_RD_CNT; k++) begin
            pi = PW'((32'(rr_q[b]) + 32'(k)) % PORT_RD_CNT);
            // Forced drain owns the head bank for the whole cycle.
            if (!bank_busy[b] && !(full && head_bank == BANK_W'(b)) &&
                rd_valid_i[pi] && bank_of(rd_addr_i[pi]) == BANK_W'(b)) begin
               bank_busy[b] = 1'b1;
               bank_win[b]  = pi;
               gnt[pi]      = 1'b1;
            end
         end
      end
   end

   // Bank data merged with pending writes, oldest first so the youngest wins.
   always_comb begin
      logic [WI_W-1:0] fi;
      fi = '0;
      for (int p = 0; p < PORT_RD_CNT; p++) begin
         rdata[p] = mem_q[bank_of(rd_addr_i[p])][row_of(rd_addr_i[p])];
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            fi = WI_W'((32'(head_q) + 32'(i)) % WBUF_DEPTH);
            if (i < int'(cnt_q) && wb_addr_q[fi] == rd_addr_i[p]) begin
               for (int j = 0; j < NB; j++) begin
                  if (wb_be_q[fi][j]) begin
                     rdata[p][8*j +: 8] = wb_data_q[fi][8*j +: 8];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         rvalid_q  <= '0;
         rd_data_q <= '0;
         for (int b = 0; b < NBANKS; b++) begin
            rr_q[b] <= '0;
         end
      end else begin
         if (accept) begin
            tail_q <= wb_inc(tail_q);
         end
         if (drain) begin
            head_q <= wb_inc(head_q);
         end
         cnt_q    <= cnt_q + CNT_W'(accept) - CNT_W'(drain);
         rvalid_q <= gnt;
         for (int p = 0; p < PORT_RD_CNT; p++) begin
            if (gnt[p]) begin
               rd_data_q[p] <= rdata[p];
            end
         end
         for (int b = 0; b < NBANKS; b++) begin
            if (bank_busy[b]) begin
               rr_q[b] <= PW'((32'(bank_win[b]) + 32'd1) % PORT_RD_CNT);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         wb_addr_q[tail_q] <= wr_addr_i;
         wb_data_q[tail_q] <= wr_data_i;
         wb_be_q[tail_q]   <= wr_be_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (drain) begin
         for (int j = 0; j < NB; j++) begin
            if (wb_be_q[head_q][j]) begin
               mem_q[head_bank][head_row][8*j +: 8] <= wb_data_q[head_q][8*j +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_vproc_vregfile_banked.sv
// Directed bench for vproc_vregfile_banked with a reference register model
// and per-port response scoreboards.
module tb_vproc_vregfile_banked;

   localparam int VW = 128;
   localparam int NB = VW / 8;
   localparam int P  = 2;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [P-1:0]             rd_valid;
   logic [P-1:0][AW-1:0]     rd_addr;
   logic [P-1:0]             rd_ready;
   logic [P-1:0]             rd_rvalid;
   logic [P-1:0][VW-1:0]     rd_data;
   logic                     wr_valid;
   logic                     wr_ready;
   logic [AW-1:0]            wr_addr;
   logic [VW-1:0]            wr_data;
   logic [NB-1:0]            wr_be;
   logic                     wbuf_empty;

   vproc_vregfile_banked dut (
      .clk_i        (clk),
      .async_rst_ni (rst_n),
      .rd_valid_i   (rd_valid),
      .rd_addr_i    (rd_addr),
      .rd_ready_o   (rd_ready),
      .rd_rvalid_o  (rd_rvalid),
      .rd_data_o    (rd_data),
      .wr_valid_i   (wr_valid),
      .wr_ready_o   (wr_ready),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .wr_be_i      (wr_be),
      .wbuf_empty_o (wbuf_empty)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [VW-1:0] ref_mem [32];
   logic [VW-1:0] sb0 [$];
   logic [VW-1:0] sb1 [$];
   logic [P-1:0]  last_rdy;
   logic          last_acc;
   logic          last_wrdy;
   logic [VW-1:0] old1;
   logic [VW-1:0] old5;

   task automatic check(input string tag, input logic [VW-1:0] obs,
                        input logic [VW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the
   // next falling edge after checking that cycle's responses.
   task automatic cyc();
      logic [P-1:0] pend;
      #1;
      last_rdy  = rd_ready;
      last_wrdy = wr_ready;
      last_acc  = wr_valid && wr_ready;
      pend      = '0;
      for (int p = 0; p < P; p++) begin
         if (last_rdy[p]) begin
            pend[p] = 1'b1;
            if (p == 0) sb0.push_back(ref_mem[rd_addr[p]]);
            else        sb1.push_back(ref_mem[rd_addr[p]]);
         end
      end
      if (last_acc) begin
         for (int j = 0; j < NB; j++) begin
            if (wr_be[j]) ref_mem[wr_addr][8*j +: 8] = wr_data[8*j +: 8];
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < P; p++) begin
         check($sformatf("rvalid[%0d]", p), VW'(rd_rvalid[p]), VW'(pend[p]));
         if (rd_rvalid[p]) begin
            if (p == 0 && sb0.size() > 0)
               check("rdata[0]", rd_data[0], sb0.pop_front());
            else if (p == 1 && sb1.size() > 0)
               check("rdata[1]", rd_data[1], sb1.pop_front());
         end
      end
   endtask

   task automatic wait_empty(input string tag);
      int n;
      n = 0;
      rd_valid = '0;
      wr_valid = 1'b0;
      while (!wbuf_empty && n < 20) begin
         cyc();
         n++;
      end
      check(tag, VW'(wbuf_empty), VW'(1));
   endtask

   task automatic set_wr(input logic [AW-1:0] a, input logic [VW-1:0] d,
                         input logic [NB-1:0] be);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_be    = be;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      rd_valid = '0;
      rd_addr  = '0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_be    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_ready", VW'(rd_ready), VW'(0));
      check("rst_rvalid", VW'(rd_rvalid), VW'(0));
      check("rst_rdata0", rd_data[0], '0);
      check("rst_rdata1", rd_data[1], '0);
      check("rst_wr_ready", VW'(wr_ready), VW'(1));
      check("rst_wbuf_empty", VW'(wbuf_empty), VW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Preload registers 0..8, one write per cycle
      for (int a = 0; a < 9; a++) begin
         set_wr(AW'(a), {$urandom, $urandom, $urandom, $urandom}, '1);
         cyc();
         check("preload_acc", VW'(last_acc), VW'(1));
      end
      wait_empty("preload_empty");

      // Basic write then read
      set_wr(5'd5, {16{8'hAA}}, '1);
      cyc();
      check("basic_acc", VW'(last_acc), VW'(1));
      wr_valid = 1'b0;
      check("basic_pending", VW'(wbuf_empty), VW'(0));
      wait_empty("basic_empty");
      rd_valid = 2'b01;
      rd_addr[0] = 5'd5;
      cyc();
      check("basic_rdy", VW'(last_rdy), VW'(2'b01));
      check("basic_data", rd_data[0], {16{8'hAA}});
      rd_valid = '0;
      cyc();
      check("basic_hold", rd_data[0], {16{8'hAA}});

      // Forwarding: bank 3 kept busy by port 1
      rd_valid = 2'b10;
      rd_addr[1] = 5'd7;
      set_wr(5'd3, {16{8'h11}}, '1);
      cyc();
      check("fwd_acc1", VW'(last_acc), VW'(1));
      check("fwd_rdy1", VW'(last_rdy), VW'(2'b10));
      set_wr(5'd3, {16{8'h22}}, 16'h000F);
      cyc();
      check("fwd_acc2", VW'(last_acc), VW'(1));
      check("fwd_rdy2", VW'(last_rdy), VW'(2'b10));
      wr_valid = 1'b0;
      cyc();
      check("fwd_full", VW'(last_wrdy), VW'(0));
      check("fwd_forced", VW'(last_rdy), VW'(2'b00));
      rd_valid = 2'b01;
      rd_addr[0] = 5'd3;
      cyc();
      check("fwd_rdy3", VW'(last_rdy), VW'(2'b01));
      check("fwd_data", rd_data[0], {{12{8'h11}}, {4{8'h22}}});
      wait_empty("fwd_empty");

      // Round-robin on bank 1
      rd_valid = 2'b10;
      rd_addr[1] = 5'd1;
      cyc();
      check("rr_prime", VW'(last_rdy), VW'(2'b10));
      rd_valid = 2'b11;
      rd_addr[0] = 5'd1;
      rd_addr[1] = 5'd5;
      cyc();
      check("rr_first", VW'(last_rdy), VW'(2'b01));
      cyc();
      check("rr_second", VW'(last_rdy), VW'(2'b10));
      rd_valid = '0;
      cyc();
      rd_valid = 2'b11;
      cyc();
      check("rr_reissue", VW'(last_rdy), VW'(2'b01));
      rd_addr[0] = 5'd0;
      rd_addr[1] = 5'd1;
      cyc();
      check("rr_parallel", VW'(last_rdy), VW'(2'b11));
      rd_valid = '0;
      cyc();

      // Full buffer with bank 0 read every cycle
      wait_empty("full_pre");
      rd_valid = 2'b01;
      rd_addr[0] = 5'd0;
      set_wr(5'd0, {$urandom, $urandom, $urandom, $urandom}, '1);
      cyc();
      check("full_acc0", VW'(last_acc), VW'(1));
      check("full_rdy0", VW'(last_rdy), VW'(2'b01));
      set_wr(5'd4, {$urandom, $urandom, $urandom, $urandom}, '1);
      cyc();
      check("full_acc4", VW'(last_acc), VW'(1));
      check("full_rdy4", VW'(last_rdy), VW'(2'b01));
      set_wr(5'd8, {$urandom, $urandom, $urandom, $urandom}, '1);
      cyc();
      check("full_wrdy", VW'(last_wrdy), VW'(0));
      check("full_noacc", VW'(last_acc), VW'(0));
      check("full_blocked", VW'(last_rdy), VW'(2'b00));
      cyc();
      check("full_acc8", VW'(last_acc), VW'(1));
      check("full_rdy_back", VW'(last_rdy), VW'(2'b01));
      wait_empty("full_empty");

      // Reset with pending writes and a granted read
      old1 = ref_mem[1];
      old5 = ref_mem[5];
      rd_valid = 2'b01;
      rd_addr[0] = 5'd1;
      set_wr(5'd1, {$urandom, $urandom, $urandom, $urandom}, '1);
      cyc();
      check("rst_acc1", VW'(last_acc), VW'(1));
      set_wr(5'd5, {$urandom, $urandom, $urandom, $urandom}, '1);
      cyc();
      check("rst_acc5", VW'(last_acc), VW'(1));
      wr_valid = 1'b0;
      rd_valid = 2'b10;
      rd_addr[1] = 5'd2;
      #1;
      check("rst_grant", VW'(rd_ready), VW'(2'b10));
      check("rst_pending", VW'(wbuf_empty), VW'(0));
      rst_n = 1'b0;
      #1;
      check("rst_empty_now", VW'(wbuf_empty), VW'(1));
      check("rst_wrdy_now", VW'(wr_ready), VW'(1));
      @(posedge clk);
      #1;
      check("rst_no_pulse", VW'(rd_rvalid), VW'(0));
      rd_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      ref_mem[1] = old1;
      ref_mem[5] = old5;
      rd_valid = 2'b11;
      rd_addr[0] = 5'd1;
      rd_addr[1] = 5'd5;
      cyc();
      check("rst_rr0", VW'(last_rdy), VW'(2'b01));
      cyc();
      check("rst_rr1", VW'(last_rdy), VW'(2'b10));
      rd_addr[0] = 5'd3;
      rd_addr[1] = 5'd2;
      cyc();
      check("rst_par", VW'(last_rdy), VW'(2'b11));
      rd_valid = 2'b01;
      rd_addr[0] = 5'd0;
      cyc();
      rd_valid = '0;
      cyc();

      check("sb_drained", VW'(sb0.size() + sb1.size()), VW'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
